// File: rtl/btn_pkg.sv
// btn_pkg: FSM state encoding and counter width shared by btn_press_detect
package btn_pkg;
  localparam int CNT_W = 8;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    HELD      = 3'd2,
    LONG      = 3'd3,
    DEB_REL   = 3'd4
  } btn_state_e;
endpackage

// File: rtl/btn_sync2.sv
// btn_sync2: two-flop synchronizer with a configurable reset value
module btn_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end
  assign q = s2_q;
endmodule

// File: rtl/btn_press_detect.sv
// btn_press_detect: debounced push-button with short/long press and force-off pulses
// Define BTN_FORCE_OFF_EN to enable force_off detection; otherwise force_off is tied low.
module btn_press_detect
  import btn_pkg::*;
#(
  parameter int DEB_TICKS   = 16,
  parameter int LONG_TICKS  = 61,
  parameter int FORCE_TICKS = 92
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       t1ms,
  input  logic       t64ms,
  input  logic       btn_n,
  output logic       btn_db,
  output logic       short_press,
  output logic       long_press,
  output logic       force_off,
  output logic [2:0] state_dbg
);
  localparam logic [CNT_W-1:0] DEB_V  = CNT_W'(DEB_TICKS);
  localparam logic [CNT_W-1:0] LONG_V = CNT_W'(LONG_TICKS);
`ifdef BTN_FORCE_OFF_EN
  localparam logic [CNT_W-1:0] FORCE_V  = CNT_W'(FORCE_TICKS);
  localparam logic [CNT_W-1:0] HOLD_SAT = '1;
`else
  localparam logic [CNT_W-1:0] HOLD_SAT = LONG_V;
`endif

  if (FORCE_TICKS <= LONG_TICKS || DEB_TICKS < 1 || DEB_TICKS > 255 ||
      LONG_TICKS < 1 || LONG_TICKS > 255) begin : g_bad_params
    $error("btn_press_detect: illegal tick parameters");
  end

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] deb_q, deb_d, hold_q, hold_d, deb_inc, hold_inc;
  logic             was_long_q, was_long_d, btn_db_q, btn_db_d;
  logic             short_q, short_d, long_q, long_d;
  logic             btn_sync, btn_s;
`ifdef BTN_FORCE_OFF_EN
  logic             force_q, force_d;
`endif

  btn_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (btn_n),
    .q      (btn_sync)
  );
  assign btn_s = ~btn_sync;

  always_comb begin
    state_d    = state_q;
    deb_d      = deb_q;
    hold_d     = hold_q;
    was_long_d = was_long_q;
    btn_db_d   = btn_db_q;
    short_d    = 1'b0;
    long_d     = 1'b0;
`ifdef BTN_FORCE_OFF_EN
    force_d    = 1'b0;
`endif
    deb_inc    = deb_q + CNT_W'(1);
    hold_inc   = hold_q + CNT_W'(1);
    case (state_q)
      IDLE: if (btn_s) begin
        state_d = DEB_PRESS;
        deb_d   = '0;
      end
      DEB_PRESS: if (!btn_s) state_d = IDLE;
      else if (t1ms) begin
        deb_d = deb_inc;
        if (deb_inc == DEB_V) begin
          state_d  = HELD;
          btn_db_d = 1'b1;
          hold_d   = '0;
        end
      end
      HELD: if (!btn_s) begin
        state_d    = DEB_REL;
        was_long_d = 1'b0;
        deb_d      = '0;
      end else if (t64ms) begin
        hold_d = hold_inc;
        if (hold_inc == LONG_V) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end
      LONG: if (!btn_s) begin
        state_d    = DEB_REL;
        was_long_d = 1'b1;
        deb_d      = '0;
      end else if (t64ms && hold_q != HOLD_SAT) begin
        hold_d  = hold_inc;
`ifdef BTN_FORCE_OFF_EN
        force_d = hold_inc == FORCE_V;
`endif
      end
      // a re-press during release debounce resumes the hold where it left off
      DEB_REL: if (btn_s) state_d = was_long_q ? LONG : HELD;
      else if (t1ms) begin
        deb_d = deb_inc;
        if (deb_inc == DEB_V) begin
          state_d  = IDLE;
          btn_db_d = 1'b0;
          short_d  = ~was_long_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      deb_q      <= '0;
      hold_q     <= '0;
      was_long_q <= 1'b0;
      btn_db_q   <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_q      <= deb_d;
      hold_q     <= hold_d;
      was_long_q <= was_long_d;
      btn_db_q   <= btn_db_d;
      short_q    <= short_d;
      long_q     <= long_d;
    end
  end

`ifdef BTN_FORCE_OFF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) force_q <= 1'b0;
    else force_q <= force_d;
  end
  assign force_off = force_q;
`else
  assign force_off = 1'b0;
`endif

  assign btn_db      = btn_db_q;
  assign short_press = short_q;
  assign long_press  = long_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_btn_press_detect.sv
// tb_btn_press_detect: directed scenarios plus randomized ticks/presses against a tick-level model
module tb_btn_press_detect;
  localparam int DEB = 16, LONG = 61, FORCE = 92;
`ifdef BTN_FORCE_OFF_EN
  localparam bit FORCE_EN = 1'b1;
`else
  localparam bit FORCE_EN = 1'b0;
`endif
  localparam int SAT = FORCE_EN ? 255 : LONG;

  logic clk = 1'b0, reset_n = 1'b0, t1ms = 1'b0, t64ms = 1'b0, btn_n = 1'b1;
  logic btn_db, short_press, long_press, force_off;
  logic [2:0] state_dbg;
  int checks = 0, errors = 0;
  int n_short = 0, n_long = 0, n_force = 0;
  int e_short = 0, e_long = 0, e_force = 0;
  bit m_raw = 1'b0, m_db = 1'b0;
  int m_run = 0, m_hold = 0;

  always #5 clk = ~clk;

  btn_press_detect dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .t1ms       (t1ms),
    .t64ms      (t64ms),
    .btn_n      (btn_n),
    .btn_db     (btn_db),
    .short_press(short_press),
    .long_press (long_press),
    .force_off  (force_off),
    .state_dbg  (state_dbg)
  );

  // every clk a pulse output is high adds one, so a stretched pulse is counted twice
  always @(posedge clk) begin
    n_short <= n_short + int'(short_press);
    n_long  <= n_long + int'(long_press);
    n_force <= n_force + int'(force_off);
  end

  // model: the debounced level flips once the raw level has disagreed with it for DEB t1ms ticks;
  // t64ms ticks while debounced-and-pressed advance the hold count
  task automatic model_tick(input bit a, input bit b);
    if (b && m_db && m_raw && m_hold < SAT) begin
      m_hold++;
      if (m_hold == LONG) e_long++;
      if (FORCE_EN && m_hold == FORCE) e_force++;
    end
    if (a && m_raw != m_db) begin
      m_run++;
      if (m_run == DEB) begin
        m_db  = m_raw;
        m_run = 0;
        if (m_db) m_hold = 0;
        else if (m_hold < LONG) e_short++;
      end
    end
  endtask

  function automatic logic [2:0] exp_state();
    if (!m_db) return m_raw ? 3'd1 : 3'd0;
    if (!m_raw) return 3'd4;
    return (m_hold >= LONG) ? 3'd3 : 3'd2;
  endfunction

  function automatic void model_reset();
    m_db = 1'b0;
    m_run = 0;
    m_hold = 0;
  endfunction

  // kind: 0 = t1ms, 1 = t64ms, 2 = both, 3 = toggle button
  task automatic step(input int kind);
    @(negedge clk);
    if (kind == 3) begin
      btn_n = ~btn_n;
      m_raw = ~m_raw;
      m_run = 0;
      repeat (4) @(negedge clk);
    end else begin
      t1ms  = (kind != 1);
      t64ms = (kind != 0);
      model_tick(kind != 1, kind != 0);
      @(negedge clk);
      t1ms  = 1'b0;
      t64ms = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    btn_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({btn_db, short_press, long_press, force_off} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0000", {btn_db, short_press, long_press, force_off});
    end
    checks++;
    if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    btn_n = 1'b0;
    repeat (20) begin @(negedge clk) t1ms = 1'b1; @(negedge clk) t1ms = 1'b0; end
    checks++;
    if (btn_db !== 1'b0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_held got db=%b st=%0d exp db=0 st=0", btn_db, state_dbg);
    end
    m_raw = 1'b1;
    model_reset();
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (state_dbg !== 3'd1) begin errors++; $display("FAIL post_reset_deb got=%0d exp=1", state_dbg); end
    for (int i = 1; i <= DEB; i++) begin
      step(0);
      checks++;
      if (btn_db !== (i >= DEB)) begin
        errors++;
        $display("FAIL post_reset_db tick=%0d got=%b exp=%b", i, btn_db, i >= DEB);
      end
    end
    step(3);
    repeat (DEB) step(0);
    checks++;
    if (btn_db !== 1'b0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_release got db=%b st=%0d exp db=0 st=0", btn_db, state_dbg);
    end
  endtask

  task automatic test_short_press();
    int s0 = n_short, l0 = n_long;
    step(3);
    for (int i = 1; i <= 20; i++) begin
      step(0);
      checks++;
      if (btn_db !== (i >= DEB)) begin
        errors++;
        $display("FAIL short_rise tick=%0d got=%b exp=%b", i, btn_db, i >= DEB);
      end
    end
    step(3);
    for (int i = 1; i <= 20; i++) begin
      step(0);
      checks++;
      if (btn_db !== (i < DEB)) begin
        errors++;
        $display("FAIL short_fall tick=%0d got=%b exp=%b", i, btn_db, i < DEB);
      end
    end
    checks++;
    if (n_short !== s0 + 1 || n_long !== l0) begin
      errors++;
      $display("FAIL short_pulses got short=%0d long=%0d exp short=%0d long=%0d", n_short - s0, n_long - l0, 1, 0);
    end
  endtask

  task automatic test_bounce();
    int s0 = n_short, l0 = n_long;
    repeat (10) begin
      step(3);
      repeat (5) step(0);
      step(3);
      repeat (2) step(0);
      checks++;
      if (btn_db !== 1'b0 || state_dbg !== 3'd0) begin
        errors++;
        $display("FAIL bounce got db=%b st=%0d exp db=0 st=0", btn_db, state_dbg);
      end
    end
    checks++;
    if (n_short !== s0 || n_long !== l0) begin
      errors++;
      $display("FAIL bounce_pulses got short=%0d long=%0d exp 0 0", n_short - s0, n_long - l0);
    end
  endtask

  task automatic test_long_press();
    int s0 = n_short, l0 = n_long, f0 = n_force;
    step(3);
    repeat (DEB) step(0);
    for (int i = 1; i <= 100; i++) begin
      step(1);
      checks++;
      if (n_long !== l0 + int'(i >= LONG) || n_force !== f0 + int'(FORCE_EN && i >= FORCE)) begin
        errors++;
        $display("FAIL long_hold tick=%0d got long=%0d force=%0d exp long=%0d force=%0d", i, n_long - l0,
                 n_force - f0, int'(i >= LONG), int'(FORCE_EN && i >= FORCE));
      end
    end
    checks++;
    if (state_dbg !== 3'd3) begin errors++; $display("FAIL long_state got=%0d exp=3", state_dbg); end
    step(3);
    repeat (DEB) step(0);
    checks++;
    if (n_short !== s0 || btn_db !== 1'b0) begin
      errors++;
      $display("FAIL long_release got short=%0d db=%b exp short=0 db=0", n_short - s0, btn_db);
    end
  endtask

  task automatic test_resume();
    int l0 = n_long, s0 = n_short;
    step(3);
    repeat (DEB) step(0);
    repeat (30) step(1);
    step(3);
    repeat (10) step(0);
    checks++;
    if (state_dbg !== 3'd4 || btn_db !== 1'b1) begin
      errors++;
      $display("FAIL resume_rel got st=%0d db=%b exp st=4 db=1", state_dbg, btn_db);
    end
    step(3);
    checks++;
    if (state_dbg !== 3'd2) begin errors++; $display("FAIL resume_held got=%0d exp=2", state_dbg); end
    for (int i = 31; i <= LONG; i++) begin
      step(1);
      checks++;
      if (n_long !== l0 + int'(i >= LONG)) begin
        errors++;
        $display("FAIL resume_long tick=%0d got=%0d exp=%0d", i, n_long - l0, int'(i >= LONG));
      end
    end
    step(3);
    repeat (DEB) step(0);
    checks++;
    if (n_short !== s0) begin errors++; $display("FAIL resume_short got=%0d exp=0", n_short - s0); end
  endtask

  task automatic test_reset_mid();
    int l0;
    step(3);
    repeat (DEB) step(0);
    repeat (50) step(1);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({btn_db, short_press, long_press, force_off} !== 4'b0000 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid got out=%b st=%0d exp out=0000 st=0",
               {btn_db, short_press, long_press, force_off}, state_dbg);
    end
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    l0 = n_long;
    for (int i = 1; i <= DEB; i++) begin
      step(0);
      checks++;
      if (btn_db !== (i >= DEB)) begin
        errors++;
        $display("FAIL reset_mid_deb tick=%0d got=%b exp=%b", i, btn_db, i >= DEB);
      end
    end
    for (int i = 1; i <= LONG; i++) begin
      step(1);
      checks++;
      if (n_long !== l0 + int'(i >= LONG)) begin
        errors++;
        $display("FAIL reset_mid_long tick=%0d got=%0d exp=%0d", i, n_long - l0, int'(i >= LONG));
      end
    end
    step(3);
    repeat (DEB) step(0);
  endtask

  task automatic test_coincide();
    int l0 = n_long;
    step(3);
    repeat (DEB) step(0);
    repeat (5) step(2);
    checks++;
    if (state_dbg !== 3'd2 || btn_db !== 1'b1) begin
      errors++;
      $display("FAIL coincide_held got st=%0d db=%b exp st=2 db=1", state_dbg, btn_db);
    end
    for (int i = 6; i <= LONG; i++) begin
      step(1);
      checks++;
      if (n_long !== l0 + int'(i >= LONG)) begin
        errors++;
        $display("FAIL coincide_long tick=%0d got=%0d exp=%0d", i, n_long - l0, int'(i >= LONG));
      end
    end
    step(3);
    for (int i = 1; i <= DEB; i++) begin
      step(0);
      checks++;
      if (btn_db !== (i < DEB)) begin
        errors++;
        $display("FAIL coincide_rel tick=%0d got=%b exp=%b", i, btn_db, i < DEB);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      int r = int'($urandom_range(999));
      int tog = m_raw ? 6 : 40;
      step(r < tog ? 3 : r < tog + 450 ? 0 : r < 900 ? 1 : 2);
      checks++;
      if (btn_db !== m_db || state_dbg !== exp_state()) begin
        errors++;
        $display("FAIL rand_state step=%0d got db=%b st=%0d exp db=%b st=%0d", n, btn_db, state_dbg, m_db, exp_state());
      end
      checks++;
      if (n_short !== e_short || n_long !== e_long || n_force !== e_force) begin
        errors++;
        $display("FAIL rand_pulses step=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", n, n_short, n_long, n_force,
                 e_short, e_long, e_force);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_bounce();
    test_long_press();
    test_resume();
    test_reset_mid();
    test_coincide();
    e_short = n_short;
    e_long  = n_long;
    e_force = n_force;
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
